sram_ctrl: RTL

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// Turns a single-word load/store request from the memory-access stage into an
// asynchronous SRAM cycle: SETUP (1 cycle), ACCESS (WAIT_CYCLES cycles) and
// DONE (1 cycle, ack). Latency from request accepted in IDLE at cycle T to ack
// is T+2+WAIT_CYCLES. All SRAM-side outputs are registered.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   req_i        access request, held until ack_o
//   we_i         1 = store, 0 = load (valid with req_i)
//   addr_i       16-bit word address (valid with req_i)
//   wdata_i      store data (valid with req_i)
//   rdata_o      load result, valid from ack until the next load completes
//   ack_o        one-cycle completion pulse
//   stall_o      pipeline hold = req_i & ~ack_o
//   sram_addr_o  18-bit SRAM address (zero-extended word address)
//   sram_dq_i    SRAM data bus, read side
//   sram_dq_o    SRAM data bus, drive side
//   sram_dq_oe   1 = drive sram_dq_o onto the bus
//   sram_ce_n    chip enable, active low
//   sram_oe_n    output enable, active low
//   sram_we_n    write enable, active low
// -----------------------------------------------------------------------------
module sram_ctrl #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [15:0] addr_i,
   input  logic [15:0] wdata_i,
   output logic [15:0] rdata_o,
   output logic        ack_o,
   output logic        stall_o,
   output logic [17:0] sram_addr_o,
   input  logic [15:0] sram_dq_i,
   output logic [15:0] sram_dq_o,
   output logic        sram_dq_oe,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] LP_CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [17:0] r_addr;
   logic [15:0] r_dq_o;
   logic [15:0] r_rdata;
   logic        r_ack;
   logic        r_dq_oe;
   logic        r_ce_n;
   logic        r_oe_n;
   logic        r_we_n;

   // Each transition also loads the strobe values for the state being
   // entered, so the strobes are registered and line up with r_state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= 18'd0;
         r_dq_o  <= 16'd0;
         r_rdata <= 16'd0;
         r_ack   <= 1'b0;
         r_dq_oe <= 1'b0;
         r_ce_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_i) begin
                  r_state <= SETUP;
                  r_we    <= we_i;
                  r_addr  <= {2'b00, addr_i};
                  r_dq_o  <= wdata_i;
                  r_ce_n  <= 1'b0;
                  // Loads enable the SRAM output; stores drive the bus.
                  // The two are mutually exclusive by construction.
                  r_oe_n  <= we_i;
                  r_dq_oe <= we_i;
                  r_we_n  <= 1'b1;
               end
            end
            SETUP: begin
               r_state <= ACCESS;
               r_cnt   <= LP_CNT_INIT;
               r_we_n  <= ~r_we;
            end
            ACCESS: begin
               if (r_cnt == 4'd0) begin
                  r_state <= DONE;
                  r_ack   <= 1'b1;
                  r_we_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  // A store keeps the chip selected and the data driven
                  // through DONE for write hold time.
                  r_ce_n  <= ~r_we;
                  if (!r_we) begin
                     r_rdata <= sram_dq_i;
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_ce_n  <= 1'b1;
               r_oe_n  <= 1'b1;
               r_we_n  <= 1'b1;
               r_dq_oe <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign rdata_o     = r_rdata;
   assign ack_o       = r_ack;
   assign stall_o     = req_i & ~r_ack;
   assign sram_addr_o = r_addr;
   assign sram_dq_o   = r_dq_o;
   assign sram_dq_oe  = r_dq_oe;
   assign sram_ce_n   = r_ce_n;
   assign sram_oe_n   = r_oe_n;
   assign sram_we_n   = r_we_n;

endmodule
